// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator input path.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_CHECKSUM,
    ERR_BUSY
  } loader_err_t;

  localparam int         IMG_BYTES   = 64;
  localparam logic [7:0] SOF_DEFAULT = 8'h01;

endpackage

// File: rtl/rx_timeout_timer.sv
// Idle-gap timer for the frame loader. Counts enabled cycles since the last
// clear and flags expiry on the cycle that brings the count to
// TIMEOUT_CYCLES-1, so the owner sees the abort exactly that many idle
// cycles after the last activity.
module rx_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Idle counter: restarts on any activity, advances on each idle cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry is only reported on an idle cycle, so a byte arriving in the
  // same cycle always wins over the timeout.
  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/uart_frame_loader.sv
// UART frame loader: waits for a start-of-frame byte, then streams the
// following N_BYTES payload bytes into BRAM A and pulses frame_done once the
// last write has landed. Stalled links are aborted by a timeout, and a new
// frame is rejected while the downstream pipeline is still busy.
// Optional build macro FRAME_CHECKSUM_EN adds a trailing checksum byte that
// must bring the mod-256 payload sum to zero before frame_done is issued.
module uart_frame_loader
  import cnn_pkg::*;
#(
  parameter int         N_BYTES        = IMG_BYTES,
  parameter int         ADDR_W         = 6,
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              consumer_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              loading,
  output logic [ADDR_W:0]   byte_count,
  output logic              frame_done,
  output logic              frame_error,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W:0] BC_LAST = (ADDR_W + 1)'(N_BYTES - 1);
  localparam logic [ADDR_W:0] BC_ONE  = (ADDR_W + 1)'(1);

  loader_state_t     state, state_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              loading_n;
  logic [ADDR_W:0]   byte_count_n;
  logic              frame_done_n;
  logic              frame_error_n;
  logic [1:0]        err_code_n;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]        sum, sum_n;
  logic [7:0]        check_total;
`endif

  logic in_frame;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  // The timer only runs inside a frame and restarts on every received byte.
  assign in_frame     = (state == LOAD) || (state == CHECK);
  assign timer_clear  = !in_frame || rx_ready;
  assign timer_enable = in_frame && !rx_ready;

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_enable),
    .expire(timer_expire)
  );

  // State and output registers; every output leaves the block from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      loading     <= 1'b0;
      byte_count  <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      state       <= state_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      loading     <= loading_n;
      byte_count  <= byte_count_n;
      frame_done  <= frame_done_n;
      frame_error <= frame_error_n;
      err_code    <= err_code_n;
`ifdef FRAME_CHECKSUM_EN
      sum         <= sum_n;
`endif
    end
  end

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_n       = state;
    wr_en_n       = 1'b0;
    wr_addr_n     = wr_addr;
    wr_data_n     = wr_data;
    loading_n     = loading;
    byte_count_n  = byte_count;
    frame_done_n  = 1'b0;
    frame_error_n = 1'b0;
    err_code_n    = err_code;
`ifdef FRAME_CHECKSUM_EN
    sum_n         = sum;
    check_total   = sum + rx_data;
`endif

    case (state)
      IDLE: begin
        if (rx_ready && (rx_data == SOF_BYTE)) begin
          if (consumer_busy) begin
            frame_error_n = 1'b1;
            err_code_n    = ERR_BUSY;
          end else begin
            state_n      = LOAD;
            loading_n    = 1'b1;
            byte_count_n = '0;
`ifdef FRAME_CHECKSUM_EN
            sum_n        = '0;
`endif
          end
        end
      end

      LOAD: begin
        if (rx_ready) begin
          wr_en_n      = 1'b1;
          wr_addr_n    = byte_count[ADDR_W-1:0];
          wr_data_n    = rx_data;
          byte_count_n = byte_count + BC_ONE;
`ifdef FRAME_CHECKSUM_EN
          sum_n        = sum + rx_data;
          if (byte_count == BC_LAST) state_n = CHECK;
`else
          if (byte_count == BC_LAST) state_n = DONE;
`endif
        end else if (timer_expire) begin
          state_n       = IDLE;
          loading_n     = 1'b0;
          frame_error_n = 1'b1;
          err_code_n    = ERR_TIMEOUT;
        end
      end

`ifdef FRAME_CHECKSUM_EN
      CHECK: begin
        if (rx_ready) begin
          state_n   = IDLE;
          loading_n = 1'b0;
          if (check_total == 8'h00) begin
            frame_done_n = 1'b1;
          end else begin
            frame_error_n = 1'b1;
            err_code_n    = ERR_CHECKSUM;
          end
        end else if (timer_expire) begin
          state_n       = IDLE;
          loading_n     = 1'b0;
          frame_error_n = 1'b1;
          err_code_n    = ERR_TIMEOUT;
        end
      end
`endif

      // DONE holds for one cycle so the last BRAM write lands before the
      // control unit is told the frame is ready.
      DONE: begin
        state_n      = IDLE;
        loading_n    = 1'b0;
        frame_done_n = 1'b1;
      end

      default: begin
        state_n   = IDLE;
        loading_n = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Upstream input stage of the CNN accelerator. It receives bytes from the UART receiver, detects a start-of-frame byte and writes the following 64-byte 8x8 input image into input BRAM A over its write port. When the frame is complete it signals the control unit with frame_done. It guards against stalled links with a timeout and rejects new frames while the compute pipeline is busy.

Parameters:
N_BYTES, 64, payload bytes per frame (8x8 image)
ADDR_W, 6, BRAM A address width; N_BYTES must be 2**ADDR_W
SOF_BYTE, 8'h01, start-of-frame marker value
TIMEOUT_CYCLES, 1_000_000, max idle clk cycles between bytes inside a frame (10 ms at 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
rx_data  in  8  byte from uart_basic, valid while rx_ready=1
rx_ready  in  1  1-cycle strobe: new byte available
consumer_busy  in  1  high while control unit / conv stages are processing the previous frame
wr_en  out  1  BRAM A port-A write enable
wr_addr  out  ADDR_W  BRAM A write address
wr_data  out  8  BRAM A write data
loading  out  1  high from SOF acceptance until frame end or abort
byte_count  out  ADDR_W+1  payload bytes accepted in the current frame
frame_done  out  1  1-cycle pulse: full frame written to BRAM A
frame_error  out  1  1-cycle pulse: frame aborted or rejected
err_code  out  2  cause of last error, held until next error: 0 none, 1 timeout, 2 checksum, 3 busy-reject

Behaviour:
- Reset, clk and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, loading=0, byte_count=0, frame_done=0, frame_error=0, err_code=0, state=IDLE, timer=0.
- All outputs are registered.
- IDLE:
  - rx_ready with rx_data==SOF_BYTE and consumer_busy=0 -> LOAD; loading=1 next cycle; byte_count=0; timer=0.
  - rx_ready with SOF_BYTE and consumer_busy=1 -> stay IDLE; frame_error pulse next cycle; err_code=3.
  - Any other byte in IDLE is ignored.
- LOAD:
  - Each rx_ready writes the byte: wr_en=1, wr_addr=byte_count[ADDR_W-1:0], wr_data=rx_data, all one cycle after the strobe; byte_count increments in the same cycle; timer clears.
  - A byte equal to SOF_BYTE inside LOAD is payload, not a new frame.
  - The 64th byte (byte_count reaches N_BYTES) -> DONE, or CHECK when the optional checksum feature is enabled.
- DONE:
  - Strobe of last byte at cycle T -> wr_en at T+1 -> frame_done pulse at T+2, so the write has landed before the control unit reads.
  - Then -> IDLE; loading drops with the pulse.
- Timeout: in LOAD or CHECK the timer counts every cycle without rx_ready. When it reaches TIMEOUT_CYCLES-1: frame_error pulse, err_code=1, -> IDLE, loading=0. If rx_ready arrives in the same cycle the timer expires, the byte wins and the timer clears.
- Partial or aborted frames leave BRAM A contents stale; frame_done is never issued for them.
- Reset mid-frame: immediate return to reset values; no frame_done or frame_error pulse.
- consumer_busy is sampled only at SOF acceptance; a rise during LOAD does not affect the frame.
- frame_done and frame_error are mutually exclusive and never assert in the same cycle.

Optional Feature:
Macro FRAME_CHECKSUM_EN.
- Defined: state CHECK follows the 64th payload byte and expects one more byte. A running 8-bit sum of the payload (mod 256) plus the checksum byte must equal 8'h00. On a match, frame_done pulses one cycle after the checksum strobe. On a mismatch, frame_error pulses with err_code=2 and there is no frame_done. The checksum byte is never written to BRAM.
- Undefined: no CHECK state and no sum register; the frame ends after byte 64 as described under DONE.

Decomposition:
- Package cnn_pkg holds:
  - loader_state_t {IDLE, LOAD, CHECK, DONE}
  - loader_err_t {ERR_NONE, ERR_TIMEOUT, ERR_CHECKSUM, ERR_BUSY}
  - localparams IMG_BYTES=64 and SOF_DEFAULT=8'h01
- One sub-module, rx_timeout_timer: clear/enable inputs, expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Send 0x01 then bytes 0x00..0x3F, consumer_busy=0 -> 64 writes with wr_addr=k and wr_data=k; frame_done pulse exactly 2 cycles after the last strobe; byte_count=64; err_code=0.
- Send 0x05, 0x07, then a valid frame -> the first two bytes produce no writes; the frame loads normally.
- consumer_busy=1 at SOF -> no wr_en, frame_error pulse, err_code=3; repeat with busy=0 -> normal frame_done.
- SOF plus 10 bytes, then silence (TIMEOUT_CYCLES=1000 in the bench) -> frame_error at 999 idle cycles, err_code=1, loading=0; a new SOF then loads correctly.
- Assert reset after byte 30 -> all outputs return to 0 the next cycle with no pulses; a following full frame succeeds.
- FRAME_CHECKSUM_EN with payload all 0x01 and checksum 0xC0 -> frame_done. Same payload with checksum 0xC1 -> frame_error, err_code=2, 64 writes only.
